// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, default Cortex-M0 SoC address map and small
// decode helpers used by the decoder/mux and its default slave.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // Default SoC map: code RAM, data RAM, LED controller, UART.
  localparam logic [31:0] RAMCODE_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAMCODE_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] RAMDATA_BASE    = 32'h2000_0000;
  localparam logic [31:0] RAMDATA_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] WATERLIGHT_BASE = 32'h4000_0000;
  localparam logic [31:0] WATERLIGHT_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] UART_BASE       = 32'h4000_0010;
  localparam logic [31:0] UART_MASK       = 32'hFFFF_FFF0;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: answers unmapped active transfers with a two-cycle
// ERROR response and records a saturating error count plus the faulting address.
module ahblite_default_slave
  import ahblite_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         haddr_i,
  input  logic [1:0]          htrans_i,
  input  logic                hready_i,
  input  logic                unmapped_i,
  output logic                ready_o,
  output logic                resp_o,
  output logic [ERRCNT_W-1:0] err_count_o,
  output logic [31:0]         err_addr_o
);

  ds_state_e           state_q, state_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic                err_start;

  assign err_start = unmapped_i & hready_i & is_active(htrans_i);

  // NOTE: every variable written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (err_start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = err_start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Outputs depend on the current state only, keeping the HREADY feedback
  // through the top-level mux free of combinational loops.
  always_comb begin
    ready_o = 1'b1;
    resp_o  = HRESP_OKAY;
    unique case (state_q)
      DS_ERR1: begin
        ready_o = 1'b0;
        resp_o  = HRESP_ERROR;
      end
      DS_ERR2: resp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (state_d == DS_ERR1) begin
      err_addr_d = haddr_i;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs before any of them update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DS_IDLE;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_count_o = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: rtl/ahblite_decoder_mux.sv
// Parametrised AHB-Lite address decoder and slave-to-master response mux with
// a registered data-phase select and a built-in default (error) slave.
module ahblite_decoder_mux
  import ahblite_pkg::*;
#(
  parameter int                      NUM_SLV  = 4,
  parameter logic [NUM_SLV-1:0]      SLV_EN   = 4'b1111,
  parameter logic [32*NUM_SLV-1:0]   SLV_BASE = {UART_BASE, WATERLIGHT_BASE,
                                                 RAMDATA_BASE, RAMCODE_BASE},
  parameter logic [32*NUM_SLV-1:0]   SLV_MASK = {UART_MASK, WATERLIGHT_MASK,
                                                 RAMDATA_MASK, RAMCODE_MASK},
  parameter int                      ERRCNT_W = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic                    HREADY,
  output logic [31:0]             HRDATA,
  output logic                    HRESP,
  output logic [NUM_SLV-1:0]      P_HSEL,
  input  logic [NUM_SLV-1:0]      P_HREADYOUT,
  input  logic [NUM_SLV-1:0]      P_HRESP,
  input  logic [32*NUM_SLV-1:0]   P_HRDATA,
  output logic [ERRCNT_W-1:0]     ERR_COUNT,
  output logic [31:0]             ERR_ADDR
);

  logic [NUM_SLV-1:0] hsel;
  logic               no_match;
  logic [NUM_SLV:0]   sel_q, sel_d;
  logic               ds_ready, ds_resp;

  // Priority decode: the first enabled port that matches wins.
  always_comb begin
    hsel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hsel == '0 && SLV_EN[i] &&
          addr_hit(HADDR, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32]))
        hsel[i] = 1'b1;
    end
  end

  assign no_match = ~|hsel;
  assign P_HSEL   = hsel;

  // The data-phase owner only changes when the current data phase completes.
  assign sel_d = HREADY ? {no_match, hsel} : sel_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) sel_q <= {1'b1, {NUM_SLV{1'b0}}};
    else        sel_q <= sel_d;
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    if (sel_q[NUM_SLV]) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        HREADY = P_HREADYOUT[i];
        HRESP  = P_HRESP[i];
        HRDATA = P_HRDATA[32*i +: 32];
      end
    end
  end

  ahblite_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .clk         (HCLK),
    .rst         (HRESET),
    .haddr_i     (HADDR),
    .htrans_i    (HTRANS),
    .hready_i    (HREADY),
    .unmapped_i  (no_match),
    .ready_o     (ds_ready),
    .resp_o      (ds_resp),
    .err_count_o (ERR_COUNT),
    .err_addr_o  (ERR_ADDR)
  );

endmodule

// File: doc/ahblite_decoder_mux.md
# ahblite_decoder_mux

Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for the Cortex-M0 SoC bus. It sits between the single master (the core) and up to `NUM_SLV` slaves. It replaces the fixed four-port decoder with a configurable address map and a registered data-phase select. It adds a built-in default slave that answers unmapped transfers with a two-cycle ERROR, plus a saturating error counter and last-error-address capture for debug.

## Interface
Parameters:
- `NUM_SLV`, 4: number of slave ports, 1..16.
- `SLV_EN`, 4'b1111: per-port enable bit; a disabled port never matches.
- `SLV_BASE`, {32'h4000_0010, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}: flattened base addresses; port i uses bits [32i+31:32i].
- `SLV_MASK`, {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000}: flattened compare masks, laid out the same way as `SLV_BASE`.
- `ERRCNT_W`, 16: width of the error counter.

Ports:
- `HCLK`  in  1  bus clock; all state updates on the rising edge.
- `HRESET`  in  1  asynchronous, active-high reset.
- `HADDR`  in  32  master address.
- `HTRANS`  in  2  master transfer type.
- `HREADY`  out  1  muxed ready to the master; also fed back to every slave.
- `HRDATA`  out  32  muxed read data.
- `HRESP`  out  1  muxed response; 0 = OKAY, 1 = ERROR.
- `P_HSEL`  out  NUM_SLV  per-slave select (address phase).
- `P_HREADYOUT`  in  NUM_SLV  per-slave ready.
- `P_HRESP`  in  NUM_SLV  per-slave response.
- `P_HRDATA`  in  32*NUM_SLV  per-slave read data, flattened; port i uses bits [32i+31:32i].
- `ERR_COUNT`  out  ERRCNT_W  number of unmapped active transfers; saturates at all ones.
- `ERR_ADDR`  out  32  HADDR of the most recent unmapped active transfer.

## Operation
- Address match: port i matches when `SLV_EN[i]` is set and `(HADDR & MASK_i) == BASE_i`.
  - When several ports match, the lowest index wins.
  - `P_HSEL` is purely combinational and one-hot or zero.
- No match selects the internal default slave, index `NUM_SLV`.
- Data-phase select `sel_q` (NUM_SLV+1 bits, one-hot) loads the current address-phase select when `HREADY` is 1. It holds its value otherwise.
- Output mux is driven by `sel_q`:
  - `HREADY`, `HRESP` and `HRDATA` come from the selected slave.
  - When the default slave is selected: `HRDATA` = 0, and `HREADY`/`HRESP` come from the default-slave FSM.
- Default-slave FSM has three states: `IDLE`, `ERR1`, `ERR2`.
  - `IDLE`: outputs ready=1, resp=0. An active transfer (`HTRANS[1]`=1) with `HREADY`=1 and no match moves to `ERR1`. IDLE or BUSY transfers to the default slave give a zero-wait OKAY.
  - `ERR1`: outputs ready=0, resp=1. Always moves to `ERR2`.
  - `ERR2`: outputs ready=1, resp=1. Moves to `ERR1` if a new unmapped active transfer is sampled this cycle, otherwise to `IDLE`.
- Error capture: on each entry to `ERR1`, `ERR_COUNT` increments (holding at max) and `ERR_ADDR` loads `HADDR`.

## Timing
- Reset values:
  - `sel_q` = default slave; FSM = `IDLE`.
  - `HREADY`=1, `HRESP`=0, `HRDATA`=0.
  - `ERR_COUNT`=0, `ERR_ADDR`=0.
  - `P_HSEL` follows `HADDR` combinationally even during reset.
- Mapped transfer: adds no latency. Wait states are exactly those inserted by the slave's `HREADYOUT`.
- Unmapped active transfer: the data phase takes exactly 2 cycles (ERROR with ready low, then ERROR with ready high).
- Back-to-back unmapped transfers: repeat the `ERR1`/`ERR2` pair with no `IDLE` cycle in between.
- Address phase during a stalled data phase (`HREADY`=0): it is ignored by `sel_q`, the FSM and the counters.
- Reset asserted mid-transfer: all state returns to its reset value immediately and asynchronously. No pending ERROR survives.

## Structure
- Shared package `ahblite_pkg`:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP codes: OKAY=0, ERROR=1.
  - Default SoC map constants: RAMCODE, RAMDATA, WaterLight, UART.
- Sub-module `ahblite_default_slave` contains the FSM and the error counter/address capture.
- The decode logic and output mux stay in the top module.

## Test plan
- Read 0x2000_0004 with RAMDATA (port 1) `P_HRDATA`=0xDEADBEEF: `P_HSEL`=4'b0010 in the address phase; next cycle `HRDATA`=0xDEADBEEF, `HRESP`=0.
- NONSEQ to 0x3000_0000: `P_HSEL`=0; then ready=0/resp=1, then ready=1/resp=1; `ERR_COUNT`=1, `ERR_ADDR`=0x3000_0000.
- IDLE transfer to 0x3000_0000: zero-wait OKAY; `ERR_COUNT` unchanged.
- Three consecutive unmapped NONSEQs: six ERROR cycles with no IDLE gap; `ERR_COUNT`=3. With `ERRCNT_W`=2 and five errors, `ERR_COUNT` saturates at 3.
- UART (port 3) holds `HREADYOUT`=0 for 3 cycles while the next address is unmapped: `HREADY` stays low for 3 cycles, then the ERROR pair follows. `sel_q` does not change during the stall.
- `HRESET` pulsed during `ERR1`: `HREADY`=1 and `HRESP`=0 in the same cycle; FSM returns to `IDLE`.
